// File: rtl/simd_stage_chain.sv
// simd_stage_chain: NUM_STAGES chained, registered integer SIMD stages.
// Each stage has two 4:1 operand muxes (prev / aux / imm / RF) and a private
// register file. The chain has a valid/ready elastic interface with a single
// global stall.
// Optional build macro: SIMD_STAGE_CHAIN_SAT_EN selects unsigned saturating
// arithmetic. When it is undefined, all operations wrap modulo 2^DW.
module simd_stage_chain #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned DW         = 64,
  parameter int unsigned RF_DEPTH   = 16,
  parameter int unsigned AW         = $clog2(RF_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_LANES*DW-1:0]              in_data,
  input  logic [NUM_LANES*DW-1:0]              in_aux,
  input  logic [NUM_STAGES*2-1:0]              cfg_op,
  input  logic [NUM_STAGES*2-1:0]              cfg_sel_a,
  input  logic [NUM_STAGES*2-1:0]              cfg_sel_b,
  input  logic [NUM_STAGES*DW-1:0]             cfg_imm,
  input  logic [NUM_STAGES-1:0]                cfg_rf_wen,
  input  logic [NUM_STAGES*AW-1:0]             cfg_rf_waddr,
  input  logic [NUM_STAGES*AW-1:0]             cfg_rf_raddr,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_LANES*DW-1:0]              out_data,
  output logic [NUM_STAGES-1:0]                tap_valid,
  output logic [NUM_STAGES*NUM_LANES*DW-1:0]   tap_data
);

  localparam int unsigned LW = NUM_LANES * DW;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SRC_PREV = 2'd0,
    SRC_AUX  = 2'd1,
    SRC_IMM  = 2'd2,
    SRC_RF   = 2'd3
  } src_e;

  function automatic logic [DW-1:0] alu(input op_e op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
`ifdef SIMD_STAGE_CHAIN_SAT_EN
    logic [DW:0]     sum;
    logic [2*DW-1:0] prod;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (op)
      OP_ADD:  alu = sum[DW] ? '1 : sum[DW-1:0];
      OP_SUB:  alu = (a < b) ? '0 : a - b;
      OP_MUL:  alu = (|prod[2*DW-1:DW]) ? '1 : prod[DW-1:0];
      default: alu = a;
    endcase
`else
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_MUL:  alu = a * b;
      default: alu = a;
    endcase
`endif
  endfunction

  function automatic logic [DW-1:0] operand(input src_e sel, input logic [DW-1:0] prev,
                                            input logic [DW-1:0] aux, input logic [DW-1:0] imm,
                                            input logic [DW-1:0] rf);
    case (sel)
      SRC_PREV: operand = prev;
      SRC_AUX:  operand = aux;
      SRC_IMM:  operand = imm;
      default:  operand = rf;
    endcase
  endfunction

  // Inter-stage buses: entry s is what stage s sees on its inputs;
  // entry s+1 of data/valid is stage s's registered output.
  logic [NUM_STAGES:0]           valid_bus;
  logic [NUM_STAGES:0][LW-1:0]   data_bus;
  logic [NUM_STAGES-1:0][LW-1:0] aux_bus;
  logic                          en;

  assign valid_bus[0] = in_valid;
  assign data_bus[0]  = in_data;
  assign aux_bus[0]   = in_aux;

  // Global stall: everything advances unless the last slot is full and blocked.
  assign en        = !valid_bus[NUM_STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = valid_bus[NUM_STAGES];
  assign out_data  = data_bus[NUM_STAGES];
  assign tap_valid = valid_bus[NUM_STAGES:1];
  assign tap_data  = data_bus[NUM_STAGES:1];

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    op_e                         op_s;
    src_e                        sel_a_s;
    src_e                        sel_b_s;
    logic [DW-1:0]               imm_s;
    logic [AW-1:0]               waddr_s;
    logic [AW-1:0]               raddr_s;
    logic                        v_q;
    logic [LW-1:0]               res_q;
    logic [LW-1:0]               res_d;
    logic [LW-1:0]               rf_rdata;
    logic [RF_DEPTH-1:0][LW-1:0] rf_q;

    assign op_s     = op_e'(cfg_op[2*s +: 2]);
    assign sel_a_s  = src_e'(cfg_sel_a[2*s +: 2]);
    assign sel_b_s  = src_e'(cfg_sel_b[2*s +: 2]);
    assign imm_s    = cfg_imm[s*DW +: DW];
    assign waddr_s  = cfg_rf_waddr[s*AW +: AW];
    assign raddr_s  = cfg_rf_raddr[s*AW +: AW];
    assign rf_rdata = rf_q[raddr_s];

    // Per-lane operand selection and arithmetic on the value entering this stage.
    always_comb begin
      res_d = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        res_d[l*DW +: DW] = alu(op_s,
          operand(sel_a_s, data_bus[s][l*DW +: DW], aux_bus[s][l*DW +: DW], imm_s,
                  rf_rdata[l*DW +: DW]),
          operand(sel_b_s, data_bus[s][l*DW +: DW], aux_bus[s][l*DW +: DW], imm_s,
                  rf_rdata[l*DW +: DW]));
      end
    end

    // Stage result, valid and RF write; the RF write lands with the result so a
    // same-address read sees the new value one cycle later.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q   <= 1'b0;
        res_q <= '0;
        rf_q  <= '0;
      end else if (en) begin
        v_q   <= valid_bus[s];
        res_q <= res_d;
        if (valid_bus[s] && cfg_rf_wen[s]) begin
          rf_q[waddr_s] <= res_d;
        end
      end
    end

    assign valid_bus[s+1] = v_q;
    assign data_bus[s+1]  = res_q;

    // The last stage's aux copy is never consumed, so only inner stages keep one.
    if (s < NUM_STAGES - 1) begin : g_aux
      logic [LW-1:0] aux_q;

      // Aux side stream travels with its phit.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          aux_q <= '0;
        end else if (en) begin
          aux_q <= aux_bus[s];
        end
      end

      assign aux_bus[s+1] = aux_q;
    end
  end

endmodule

// File: tb/tb_simd_stage_chain.sv
// tb_simd_stage_chain: directed and random stimulus against a transaction-level
// reference model of simd_stage_chain.
module tb_simd_stage_chain;
  localparam int NS = 4;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int RD = 16;
  localparam int AW = 4;
  localparam int LW = NL * DW;

`ifdef SIMD_STAGE_CHAIN_SAT_EN
  localparam logic [DW-1:0] SUB_EXP = 16'h0000;
  localparam logic [DW-1:0] MUL_EXP = 16'hFFFF;
`else
  localparam logic [DW-1:0] SUB_EXP = 16'hFFFF;
  localparam logic [DW-1:0] MUL_EXP = 16'h0000;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [LW-1:0]     in_data, in_aux, out_data;
  logic [2*NS-1:0]   cfg_op, cfg_sel_a, cfg_sel_b;
  logic [NS*DW-1:0]  cfg_imm;
  logic [NS-1:0]     cfg_rf_wen, tap_valid;
  logic [NS*AW-1:0]  cfg_rf_waddr, cfg_rf_raddr;
  logic [NS*LW-1:0]  tap_data;

  always #5 clk = ~clk;

  simd_stage_chain #(
    .NUM_STAGES(NS),
    .NUM_LANES (NL),
    .DW        (DW),
    .RF_DEPTH  (RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_aux      (in_aux),
    .cfg_op      (cfg_op),
    .cfg_sel_a   (cfg_sel_a),
    .cfg_sel_b   (cfg_sel_b),
    .cfg_imm     (cfg_imm),
    .cfg_rf_wen  (cfg_rf_wen),
    .cfg_rf_waddr(cfg_rf_waddr),
    .cfg_rf_raddr(cfg_rf_raddr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .tap_valid   (tap_valid),
    .tap_data    (tap_data)
  );

  int total = 0;
  int bad   = 0;

  // Bench-side configuration, one entry per stage.
  logic [1:0]    c_op  [NS];
  logic [1:0]    c_sa  [NS];
  logic [1:0]    c_sb  [NS];
  logic [DW-1:0] c_imm [NS];
  logic          c_wen [NS];
  logic [AW-1:0] c_wa  [NS];
  logic [AW-1:0] c_ra  [NS];

  // Reference model: per-stage RF contents and the slot occupancy of the chain.
  // Each accepted phit is pushed through every stage at acceptance time; with
  // config held steady while phits are in flight this matches the hardware order.
  logic [LW-1:0] m_rf [NS][RD];
  typedef struct packed {
    logic                  v;
    logic [NS-1:0][LW-1:0] r;
  } slot_t;
  slot_t pipe [NS];
  logic [DW-1:0] got_q [$];

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rep(input logic [DW-1:0] x);
    logic [LW-1:0] y;
    for (int l = 0; l < NL; l++) y[l*DW +: DW] = x;
    return y;
  endfunction

  function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input longint a, input longint b);
    longint x;
    case (op)
      2'd0:    x = a + b;
      2'd1:    x = a - b;
      2'd2:    x = a * b;
      default: x = a;
    endcase
`ifdef SIMD_STAGE_CHAIN_SAT_EN
    if (x > 65535) x = 65535;
    else if (x < 0) x = 0;
`else
    x = x & 64'hFFFF;
`endif
    return x[DW-1:0];
  endfunction

  function automatic longint pick(input logic [1:0] sel, input logic [LW-1:0] cur,
                                  input logic [LW-1:0] aux, input int s, input int l);
    case (sel)
      2'd0:    return longint'(cur[l*DW +: DW]);
      2'd1:    return longint'(aux[l*DW +: DW]);
      2'd2:    return longint'(c_imm[s]);
      default: return longint'(m_rf[s][c_ra[s]][l*DW +: DW]);
    endcase
  endfunction

  task automatic model_accept(input logic [LW-1:0] d, input logic [LW-1:0] a,
                              output logic [NS-1:0][LW-1:0] r);
    logic [LW-1:0] cur;
    logic [LW-1:0] nxt;
    cur = d;
    for (int s = 0; s < NS; s++) begin
      for (int l = 0; l < NL; l++) begin
        nxt[l*DW +: DW] = ref_op(c_op[s], pick(c_sa[s], cur, a, s, l), pick(c_sb[s], cur, a, s, l));
      end
      if (c_wen[s]) m_rf[s][c_wa[s]] = nxt;
      r[s] = nxt;
      cur  = nxt;
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < NS; p++) pipe[p] = '0;
    for (int s = 0; s < NS; s++)
      for (int e = 0; e < RD; e++) m_rf[s][e] = '0;
  endtask

  task automatic apply_cfg();
    for (int s = 0; s < NS; s++) begin
      cfg_op[2*s +: 2]        = c_op[s];
      cfg_sel_a[2*s +: 2]     = c_sa[s];
      cfg_sel_b[2*s +: 2]     = c_sb[s];
      cfg_imm[s*DW +: DW]     = c_imm[s];
      cfg_rf_wen[s]           = c_wen[s];
      cfg_rf_waddr[s*AW +: AW] = c_wa[s];
      cfg_rf_raddr[s*AW +: AW] = c_ra[s];
    end
  endtask

  task automatic cfg_defaults();
    for (int s = 0; s < NS; s++) begin
      c_op[s] = 2'd3; c_sa[s] = 2'd0; c_sb[s] = 2'd0; c_imm[s] = '0;
      c_wen[s] = 1'b0; c_wa[s] = '0; c_ra[s] = '0;
    end
    apply_cfg();
  endtask

  task automatic check_state();
    chk("out_valid", out_valid, pipe[NS-1].v);
    if (pipe[NS-1].v) chk("out_data", out_data, pipe[NS-1].r[NS-1]);
    for (int p = 0; p < NS; p++) begin
      chk($sformatf("tap_valid%0d", p), tap_valid[p], pipe[p].v);
      if (pipe[p].v) chk($sformatf("tap_data%0d", p), tap_data[p*LW +: LW], pipe[p].r[p]);
    end
  endtask

  // One clock: check in_ready, record a delivered output, advance the model.
  task automatic cycle();
    logic                  en_exp;
    logic [NS-1:0][LW-1:0] r;
    #1;
    en_exp = !pipe[NS-1].v || out_ready;
    chk("in_ready", in_ready, en_exp);
    if (out_valid && out_ready) got_q.push_back(out_data[DW-1:0]);
    @(posedge clk);
    if (en_exp) begin
      for (int p = NS - 1; p > 0; p--) pipe[p] = pipe[p-1];
      r = '0;
      if (in_valid) model_accept(in_data, in_aux, r);
      pipe[0].v = in_valid;
      pipe[0].r = r;
    end
    #1;
    check_state();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NS + 1) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_data = '0; in_aux = '0; out_ready = 1'b1;
    cfg_defaults();
    model_clear();

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_tap_valid", tap_valid, '0);
    for (int p = 0; p < NS; p++) chk($sformatf("rst_tap_data%0d", p), tap_data[p*LW +: LW], '0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;

    // Basic path: every stage adds imm=1
    for (int s = 0; s < NS; s++) begin c_op[s] = 2'd0; c_sb[s] = 2'd2; c_imm[s] = 16'd1; end
    apply_cfg();
    in_valid = 1'b1; in_data = 64'h0028_001E_0014_000A; in_aux = {$urandom, $urandom};
    cycle();
    in_valid = 1'b0; in_data = {$urandom, $urandom};
    cycle(); cycle();
    chk("basic_lat3", out_valid, 1'b0);
    cycle();
    chk("basic_lat4", out_valid, 1'b1);
    chk("basic_data", out_data, 64'h002C_0022_0018_000E);
    for (int i = 0; i < 10; i++) begin
      in_valid = ($urandom_range(0, 3) != 0); in_data = {$urandom, $urandom};
      cycle();
    end
    drain();

    // Backpressure: phits 1..6, out_ready low for 3 cycles mid-stream
    cfg_defaults();
    c_op[0] = 2'd0; c_sb[0] = 2'd2; c_imm[0] = 16'd0;
    apply_cfg();
    got_q.delete();
    begin
      int k;
      int n;
      k = 1; n = 0;
      while (k <= 6 && n < 40) begin
        in_valid  = 1'b1;
        in_data   = rep(16'(k));
        out_ready = !(n >= 4 && n < 7);
        if (!pipe[NS-1].v || out_ready) k++;
        cycle();
        if (n == 5) chk("bp_stalled_tap3", tap_valid[NS-1], 1'b1);
        n++;
      end
    end
    drain();
    chk("bp_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bp_order%0d", i), (i < got_q.size()) ? got_q[i] : 'x, 16'(i + 1));

    // RF accumulate in stage 0
    cfg_defaults();
    c_op[0] = 2'd0; c_sa[0] = 2'd0; c_sb[0] = 2'd3; c_wen[0] = 1'b1;
    apply_cfg();
    got_q.delete();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = rep(16'(i));
      cycle();
      chk($sformatf("acc_tap0_%0d", i), tap_data[LW-1:0], rep(16'(i * (i + 1) / 2)));
    end
    drain();
    chk("acc_count", got_q.size(), 3);
    chk("acc_out0", (got_q.size() > 0) ? got_q[0] : 'x, 16'd1);
    chk("acc_out1", (got_q.size() > 1) ? got_q[1] : 'x, 16'd3);
    chk("acc_out2", (got_q.size() > 2) ? got_q[2] : 'x, 16'd6);
    c_op[0] = 2'd3; c_sa[0] = 2'd3; c_wen[0] = 1'b0;
    apply_cfg();
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    cycle();
    chk("acc_rf_final", tap_data[LW-1:0], rep(16'd6));
    drain();

    // Aux operand and wrap/saturate boundaries
    cfg_defaults();
    c_op[1] = 2'd1; c_sa[1] = 2'd1; c_sb[1] = 2'd2; c_imm[1] = 16'd1;
    c_op[2] = 2'd2; c_sa[2] = 2'd2; c_sb[2] = 2'd2; c_imm[2] = 16'h0100;
    apply_cfg();
    in_valid = 1'b1; in_data = rep(16'd5); in_aux = '0;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("aux_sub_tap1", tap_data[LW +: LW], rep(SUB_EXP));
    cycle();
    chk("mul_tap2", tap_data[2*LW +: LW], rep(MUL_EXP));
    cycle();
    chk("mul_out", out_data, rep(MUL_EXP));
    drain();

    // Bubbles: 1,0,1 with accumulate at RF[5]; the bubble must not write
    cfg_defaults();
    c_op[0] = 2'd0; c_sb[0] = 2'd3; c_wa[0] = 4'd5; c_ra[0] = 4'd5; c_wen[0] = 1'b1;
    apply_cfg();
    in_valid = 1'b1; in_data = rep(16'd7);   cycle();
    in_valid = 1'b0; in_data = rep(16'd100); cycle();
    in_valid = 1'b1; in_data = rep(16'd9);   cycle();
    in_valid = 1'b0; in_data = rep(16'd100); cycle();
    chk("bub_v0", out_valid, 1'b1);
    chk("bub_d0", out_data, rep(16'd7));
    cycle();
    chk("bub_v1", out_valid, 1'b0);
    cycle();
    chk("bub_v2", out_valid, 1'b1);
    chk("bub_d2", out_data, rep(16'd16));
    drain();

    // Asynchronous reset with three phits in flight
    cfg_defaults();
    c_op[0] = 2'd0; c_sb[0] = 2'd3; c_wen[0] = 1'b1;
    apply_cfg();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = rep(16'($urandom_range(1, 50)));
      cycle();
    end
    in_valid = 1'b0;
    chk("pre_rst_tap_valid", tap_valid, 4'b0111);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tap_valid", tap_valid, '0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    for (int p = 0; p < NS; p++) chk($sformatf("mid_rst_tap%0d", p), tap_data[p*LW +: LW], '0);
    model_clear();
    #1 rst = 1'b1;
    in_valid = 1'b1; in_data = rep(16'd5);
    cycle();
    chk("post_rst_rf_zero", tap_data[LW-1:0], rep(16'd5));
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    chk("post_rst_v", out_valid, 1'b1);
    chk("post_rst_d", out_data, rep(16'd5));
    drain();

    // Random configurations, data, bubbles and backpressure
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NS; s++) begin
        c_op[s]  = 2'($urandom_range(0, 3));
        c_sa[s]  = 2'($urandom_range(0, 3));
        c_sb[s]  = 2'($urandom_range(0, 3));
        c_imm[s] = (r == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        c_wen[s] = 1'($urandom_range(0, 1));
        c_wa[s]  = 4'($urandom_range(0, 3));
        c_ra[s]  = 4'($urandom_range(0, 3));
      end
      apply_cfg();
      for (int i = 0; i < 30; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        in_data   = {$urandom, $urandom};
        in_aux    = {$urandom, $urandom};
        cycle();
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_stage_chain.md
Name: simd_stage_chain

Overview:
- Parametrised successor of the fixed six-stage SIMD data path.
- Provides a chain of NUM_STAGES identical, registered integer SIMD stages. Each stage has:
  - two 4:1 operand muxes: previous stage, aligned inbound, immediate, register-file readout;
  - a per-stage register file (RF).
- Adds a valid/ready elastic handshake with global stall, which the fixed path lacks.
- Sits between the stream ingress and the egress packetiser. Per-stage taps feed the collective engine.

Parameters:
- NUM_STAGES, 4, number of chained stages (1..16).
- NUM_LANES, 8, SIMD lanes per phit.
- DW, 64, lane width in bits.
- RF_DEPTH, 16, entries per stage RF, power of two.
- AW, $clog2(RF_DEPTH), RF address width (derived).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input phit valid.
- in_ready, out, 1, input accepted when in_valid && in_ready.
- in_data, in, NUM_LANES*DW, primary stream.
- in_aux, in, NUM_LANES*DW, inbound side stream; carried alongside the data.
- cfg_op, in, NUM_STAGES*2, per-stage op: 0 add, 1 sub (A-B), 2 mul (low DW bits), 3 pass A.
- cfg_sel_a, in, NUM_STAGES*2, operand A source: 0 prev, 1 aux, 2 imm, 3 RF.
- cfg_sel_b, in, NUM_STAGES*2, operand B source, same encoding as cfg_sel_a.
- cfg_imm, in, NUM_STAGES*DW, per-stage immediate, broadcast to all lanes.
- cfg_rf_wen, in, NUM_STAGES, per-stage RF write enable.
- cfg_rf_waddr, in, NUM_STAGES*AW, RF write address.
- cfg_rf_raddr, in, NUM_STAGES*AW, RF read address.
- out_valid, out, 1, last stage valid.
- out_ready, in, 1, downstream ready.
- out_data, out, NUM_LANES*DW, last stage result.
- tap_valid, out, NUM_STAGES, per-stage valid.
- tap_data, out, NUM_STAGES*NUM_LANES*DW, per-stage registered results; stage s is at slice s.

Behaviour:
- Reset (rst low, asynchronous):
  - all stage data, aux and valid registers clear to 0;
  - all RF entries clear to 0;
  - out_valid=0, out_data=0, tap_*=0.
  - in_ready is combinational and equals 1 while all valids are 0.
- Global enable: en = !v[NUM_STAGES-1] || out_ready. in_ready = en.
- When en=1, on each clk every stage s captures its inputs:
  - v[s] <= (s==0 ? in_valid : v[s-1]);
  - res[s] <= f(op_s, A_s, B_s) per lane;
  - aux[s] <= (s==0 ? in_aux : aux[s-1]).
- Bubbles (invalid slots) advance like data. Nothing is compressed.
- When en=0, all registers hold and no RF write occurs.
- Operand sources for stage s:
  - "prev" = in_data for s=0, else res[s-1];
  - "aux" = in_aux for s=0, else aux[s-1];
  - "imm" = cfg_imm slice s replicated across lanes;
  - "RF" = combinational read of RF_s[raddr_s] (all lanes).
- Arithmetic: per lane, unsigned modulo 2^DW.
  - add and sub wrap;
  - mul keeps the low DW bits of the product.
- RF write: occurs on a clock edge when en && incoming valid && cfg_rf_wen[s]. It writes the value being captured into res[s] to RF_s[waddr_s].
- Same-address read/write: the read returns the old value in that cycle and the new value from the next cycle. This enables one-accumulation-per-cycle.
- Latency: NUM_STAGES cycles from acceptance to out_valid with out_ready held high. Throughput is 1 phit per cycle.
- Config ports are sampled every cycle. Changing config mid-stream affects only the phits computed after the change.
- Reset asserted mid-stream discards all in-flight phits. RF contents are lost.
- out_data and tap_data are direct register outputs. There is no combinational path from in_* to out_*.

Optional Feature:
- Macro: SIMD_STAGE_CHAIN_SAT_EN.
- When defined, arithmetic saturates (unsigned):
  - add clamps to 2^DW-1;
  - sub clamps to 0;
  - mul clamps to 2^DW-1 if the product high half is nonzero.
- When undefined, all ops wrap modulo 2^DW as above. The saturation logic is not synthesised.

Test Plan:
- Basic path (NUM_STAGES=4, NUM_LANES=4, DW=16): all stages add, sel_a=prev, sel_b=imm, imm=1. Feed lanes {10,20,30,40} with out_ready=1 -> out_valid rises exactly 4 cycles after acceptance; out_data lanes {14,24,34,44}.
- Backpressure: stream 6 phits 1..6 (all lanes), stage0 add imm=0, other stages pass. Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 exactly while v[3]=1 and out_ready=0; outputs 1..6 in order, no loss, no duplication.
- RF accumulate: stage0 add, sel_a=prev, sel_b=RF, raddr=waddr=0, wen=1; other stages pass. Inputs 1,2,3 back-to-back -> tap stage0 shows 1,3,6; RF_0[0]=6 afterwards; out_data 1,3,6.
- Aux and wrap: stage1 sub, sel_a=aux, sel_b=imm=1. in_aux lanes=0 -> result 0xFFFF without SAT_EN, 0x0000 with SAT_EN. Stage2 mul 0x0100*0x0100 -> 0x0000 wrap, 0xFFFF with SAT_EN.
- Reset mid-stream: 3 phits in flight, pulse rst low for 1 cycle (asynchronous, between edges) -> out_valid and tap_valid drop to 0 immediately; RF reads return 0; the next accepted phit emerges after 4 cycles with the correct value.
- Bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 with the same spacing; no RF write occurs for the bubble slot.
